// File: rtl/cpu6_excp_ctrl.sv
// Exception/interrupt sequencer: qualifies ecall/timer-irq/mret in EX, drains MEM/WB,
// commits mepc, then redirects fetch to mtvec or mepc.
module cpu6_excp_ctrl #(
  parameter int XLEN          = 32,
  parameter int DRAIN_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            validE,
  input  logic            ecallE,
  input  logic            mretE,
  input  logic            tmr_irq_r,
  input  logic            csr_mtie_r,
  input  logic [XLEN-1:0] pcE,
  input  logic [XLEN-1:0] csr_mtvec,
  input  logic [XLEN-1:0] csr_mepc,
  input  logic            empty_pipeline_ackW,
  output logic            empty_pipeline_reqE,
  output logic [XLEN-1:0] excp_mepc,
  output logic            excp_mepc_ena,
  output logic            flushE,
  output logic            stallF,
  output logic            excp_pcsrc,
  output logic [XLEN-1:0] excp_pc,
  output logic            in_handler,
  output logic            drain_timeout
);

  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_t;

  localparam int CW = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN_TIMEOUT - 1);
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  state_t          state;
  logic            cause_trap;
  logic [XLEN-1:0] mepc_q;
  logic [XLEN-1:0] mepc_out_q;
  logic [XLEN-1:0] target_q;
  logic [CW-1:0]   cnt;
  logic            in_handler_q;
  logic            timeout_q;

  logic take_ecall, take_irq, take_mret, event_any;

  assign take_ecall = ecallE & validE;
  assign take_irq   = tmr_irq_r & csr_mtie_r & validE & ~in_handler_q;
  assign take_mret  = mretE & validE;
  assign event_any  = (state == IDLE) & (take_ecall | take_irq | take_mret);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cause_trap   <= 1'b0;
      mepc_q       <= '0;
      mepc_out_q   <= '0;
      target_q     <= '0;
      cnt          <= '0;
      in_handler_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (event_any) begin
            // ecall wins over irq, both win over mret; losers are simply dropped
            cause_trap <= take_ecall | take_irq;
            mepc_q     <= pcE;
            cnt        <= '0;
            state      <= DRAIN;
          end
        end
        DRAIN: begin
          cnt <= cnt + 1'b1;
          if (empty_pipeline_ackW) begin
            state <= COMMIT;
          end else if (cnt == CNT_LAST) begin
            state     <= COMMIT;
            timeout_q <= 1'b1;
          end
        end
        COMMIT: begin
          // CSR targets sampled only now so older csrw writes have landed
          target_q <= (cause_trap ? csr_mtvec : csr_mepc) & ALIGN_MASK;
          if (cause_trap) mepc_out_q <= mepc_q;
          state <= REDIRECT;
        end
        REDIRECT: begin
          in_handler_q <= cause_trap;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    flushE              = event_any & ~reset;
    empty_pipeline_reqE = (state == DRAIN);
    stallF              = (state == DRAIN) | (state == COMMIT);
    excp_mepc_ena       = (state == COMMIT) & cause_trap;
    excp_mepc           = excp_mepc_ena ? mepc_q : mepc_out_q;
    excp_pcsrc          = (state == REDIRECT);
    excp_pc             = target_q;
    in_handler          = in_handler_q;
    drain_timeout       = timeout_q;
  end

endmodule
